// File: rtl/gnn_weight_load_scheduler_pkg.sv
// Shared types for the weight/feature load schedulers: FSM state encoding and instruction bit positions.
package gnn_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CREDIT,
        ISSUE,
        BUSY,
        FINISH
    } sched_state_t;

    localparam int unsigned INST_WAIT_CREDIT_BIT = 0;
    localparam int unsigned INST_NOTIFY_BIT      = 1;

endpackage

// File: rtl/gnn_weight_load_scheduler_if.sv
// Decoder-to-scheduler instruction handshake plus the scheduler-to-loader ap_start/ap_done control.
interface gnn_weight_load_scheduler_if #(
    parameter int unsigned INST_W = 96,
    parameter int unsigned ADDR_W = 64
);
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] addr_offset;
    logic              wl_ap_start;
    logic [INST_W-1:0] wl_instruction;
    logic [ADDR_W-1:0] wl_addr_offset;
    logic              wl_ap_done;

    // Environment side: instruction decoder and weight loader.
    modport master (
        output inst_valid, inst_data, addr_offset, wl_ap_done,
        input  inst_ready, wl_ap_start, wl_instruction, wl_addr_offset
    );

    // Scheduler side.
    modport slave (
        input  inst_valid, inst_data, addr_offset, wl_ap_done,
        output inst_ready, wl_ap_start, wl_instruction, wl_addr_offset
    );
endinterface

// File: rtl/gnn_weight_load_scheduler_credit_counter.sv
// Up/down bank-credit counter that resets full, saturates at both ends and flags a release while full.
module gnn_credit_counter #(
    parameter int unsigned MAX_COUNT = 2,
    parameter int unsigned CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          overflow_c
);
    logic [CW-1:0] count_q;
    logic          full_c;
    logic          empty_c;

    assign full_c     = (count_q == CW'(MAX_COUNT));
    assign empty_c    = (count_q == '0);
    assign overflow_c = inc && !dec && full_c;
    assign count      = count_q;

    // Simultaneous inc and dec cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= CW'(MAX_COUNT);
        end else if (inc && !dec && !full_c) begin
            count_q <= count_q + CW'(1);
        end else if (dec && !inc && !empty_c) begin
            count_q <= count_q - CW'(1);
        end
    end
endmodule

// File: rtl/gnn_weight_load_scheduler.sv
// Issues WEIGHT instructions to the weight loader one at a time, gated on weight-bank credits.
module gnn_weight_load_scheduler
    import gnn_sched_pkg::*;
#(
    parameter int unsigned WEIGHT_INST_LENGTH = 96,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned NUM_BANKS          = 2,
    parameter int unsigned TIMEOUT_CYCLES     = 1 << 20
) (
    input  logic                         kernel_clk,
    input  logic                         kernel_rst_n,
    gnn_weight_load_scheduler_if.slave   bus,
    input  logic                         bank_release,
    output logic                         weight_ready,
    output logic                         busy,
    output logic [31:0]                  loads_done,
    output logic                         err_timeout,
    output logic                         err_credit
);
    localparam int unsigned IW = WEIGHT_INST_LENGTH;
    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned CW = $clog2(NUM_BANKS + 1);
    localparam int unsigned TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    sched_state_t  state_q;
    sched_state_t  state_d;
    logic [IW-1:0] inst_q;
    logic [AW-1:0] addr_q;
    logic [IW-1:0] wl_inst_q;
    logic [AW-1:0] wl_addr_q;
    logic          wl_start_q;
    logic          weight_ready_q;
    logic          busy_q;
    logic [31:0]   loads_done_q;
    logic          err_timeout_q;
    logic          err_credit_q;
    logic [TW-1:0] to_cnt_q;
    logic [CW-1:0] credits;
    logic          credit_ok_c;
    logic          consume_c;
    logic          credit_ovf_c;

    assign credit_ok_c = !inst_q[INST_WAIT_CREDIT_BIT] || (credits != '0);
    assign consume_c   = (state_q == CREDIT) && inst_q[INST_WAIT_CREDIT_BIT] && (credits != '0);

    gnn_credit_counter #(
        .MAX_COUNT (NUM_BANKS),
        .CW        (CW)
    ) u_credit (
        .clk        (kernel_clk),
        .rst_n      (kernel_rst_n),
        .inc        (bank_release),
        .dec        (consume_c),
        .count      (credits),
        .overflow_c (credit_ovf_c)
    );

    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.inst_valid) state_d = CREDIT;
            CREDIT:  if (credit_ok_c) state_d = ISSUE;
            ISSUE:   state_d = BUSY;
            BUSY:    if (bus.wl_ap_done) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pulse/status outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge kernel_clk or negedge kernel_rst_n) begin
        if (!kernel_rst_n) begin
            inst_q         <= '0;
            addr_q         <= '0;
            wl_inst_q      <= '0;
            wl_addr_q      <= '0;
            wl_start_q     <= 1'b0;
            weight_ready_q <= 1'b0;
            busy_q         <= 1'b0;
            loads_done_q   <= '0;
            err_timeout_q  <= 1'b0;
            err_credit_q   <= 1'b0;
            to_cnt_q       <= '0;
        end else begin
            wl_start_q     <= (state_d == ISSUE);
            weight_ready_q <= (state_d == FINISH) && inst_q[INST_NOTIFY_BIT];
            busy_q         <= (state_d != IDLE);
            if (state_q == IDLE && bus.inst_valid) begin
                inst_q <= bus.inst_data;
                addr_q <= bus.addr_offset;
            end
            if (state_q == CREDIT && credit_ok_c) begin
                wl_inst_q <= inst_q;
                wl_addr_q <= addr_q;
            end
            if (state_q == FINISH) begin
                loads_done_q <= loads_done_q + 32'd1;
            end
            // The counter saturates so a hung loader cannot wrap it back below the threshold.
            if (state_q == ISSUE) begin
                to_cnt_q <= '0;
            end else if (state_q == BUSY && TIMEOUT_CYCLES != 0) begin
                if (to_cnt_q != TW'(TIMEOUT_CYCLES)) begin
                    to_cnt_q <= to_cnt_q + TW'(1);
                end
                if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_timeout_q <= 1'b1;
                end
            end
            if (credit_ovf_c) begin
                err_credit_q <= 1'b1;
            end
        end
    end

    assign bus.inst_ready     = (state_q == IDLE);
    assign bus.wl_ap_start    = wl_start_q;
    assign bus.wl_instruction = wl_inst_q;
    assign bus.wl_addr_offset = wl_addr_q;
    assign weight_ready       = weight_ready_q;
    assign busy               = busy_q;
    assign loads_done         = loads_done_q;
    assign err_timeout        = err_timeout_q;
    assign err_credit         = err_credit_q;
endmodule
